// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester arbiter in front of a single-port bram.
// Requester 0 is the host loader and requester 1 is the compute engine.
// Each access takes three cycles (IDLE sample, ACCESS, RESP).
// Optional build macro BRAM_ARB_RR_EN selects round-robin arbitration.
// Without the macro, requester 0 has fixed priority and no pointer is built.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; the winner's command is latched on exit
// ACCESS | gnt pulse; bram driven (suppressed when out of range)
// RESP   | done pulse; bram_dout forwarded on in-range reads

module bram_arbiter #(
    parameter int unsigned MEM_WORDS = 10001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bram_en,
    output logic [3:0]  bram_wen,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        win;        // requester chosen this cycle (valid when req != 0)
    logic [31:0] sel_addr;
    logic        sel_oor;

    logic        win_q;
    logic        lat_we;
    logic        lat_oor;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        accept;

    assign accept = (state == IDLE) && (req != 2'b00);

`ifdef BRAM_ARB_RR_EN
    logic rr_last;           // requester granted most recently

    // Round-robin pointer: remembers the last winner, updated on every grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= win;
        end
    end

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        if (req == 2'b11) begin
            win = ~rr_last;
        end else begin
            win = ~req[0];
        end
    end
`else
    // Fixed-priority pick: requester 0 wins whenever it is requesting.
    always_comb begin
        win = ~req[0];
    end
`endif

    assign sel_addr = win ? addr1 : addr0;

    // Word index is the byte address divided by four; anything past the
    // last word is refused at the bram but still handshaken with an error.
    assign sel_oor = ({2'b00, sel_addr[31:2]} >= MEM_WORDS);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed three-cycle access once a request is seen.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 2'b00) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch: capture the winner's command as the access is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_oor   <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            win_q     <= win;
            lat_we    <= win ? we[1] : we[0];
            lat_oor   <= sel_oor;
            lat_addr  <= sel_addr;
            lat_wdata <= win ? wdata1 : wdata0;
        end
    end

    // Outputs decoded from state and the latched command; zero elsewhere.
    always_comb begin
        gnt       = 2'b00;
        done      = 2'b00;
        rdata     = 32'd0;
        err       = 1'b0;
        bram_en   = 1'b0;
        bram_wen  = 4'b0000;
        bram_addr = 32'd0;
        bram_din  = 32'd0;
        case (state)
            ACCESS: begin
                gnt       = win_q ? 2'b10 : 2'b01;
                bram_en   = ~lat_oor;
                bram_wen  = (lat_we && !lat_oor) ? 4'b1111 : 4'b0000;
                bram_addr = lat_addr;
                bram_din  = lat_wdata;
            end
            RESP: begin
                done  = win_q ? 2'b10 : 2'b01;
                err   = lat_oor;
                rdata = (lat_we || lat_oor) ? 32'd0 : bram_dout;
            end
            default: ;
        endcase
    end

endmodule
